muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath. Consumes the two register-file read values (rs, rt) and produces the HI/LO special registers. MFHI/MFLO results are routed through the writeback mux into the register file's `din`. Implements MULT, MULTU, DIV and DIVU with a 32-iteration shift-add / restoring-divide datapath, plus direct HI/LO writes for MTHI/MTLO.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk` in 1 — single clock; all state updates on posedge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — request an operation; sampled on posedge.
- `op` in 2 — 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val` in 32 — multiplicand or dividend (register-file read port A).
- `rt_val` in 32 — multiplier or divisor (register-file read port B).
- `hi_wr` in 1 — MTHI strobe.
- `lo_wr` in 1 — MTLO strobe.
- `wr_data` in 32 — data for MTHI/MTLO (rs value).
- `busy` out 1 — high whenever state ≠ IDLE.
- `done` out 1 — one-cycle pulse; HI/LO hold final results while high.
- `hi` out 32 — HI register.
- `lo` out 32 — LO register.
- `div_by_zero` out 1 — sticky flag, set by DIV/DIVU with `rt_val` = 0; cleared by the next accepted `start` or by reset.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start` = 1: latch `op`, operand magnitudes and sign bits; clear the iteration counter and `div_by_zero`; go to RUN.
  - Exception: divide with `rt_val` = 0 goes to DONE directly, sets `div_by_zero`, writes lo = 0xFFFFFFFF and hi = `rs_val`.
- **RUN**
  - One iteration per cycle; counter 0..31.
  - Multiply: 64-bit accumulator, shift-add on unsigned magnitudes.
  - Divide: restoring, 33-bit partial remainder, magnitude quotient.
  - On iteration 31: apply the sign fix, write HI/LO, go to DONE.
- **DONE**: `done` = 1 for one cycle, then IDLE.
- **Sign rules**
  - Signed ops use two's-complement magnitudes.
  - Product is negated if the signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - MULTU/DIVU use raw operands.
- **Results**: multiply gives hi = product[63:32], lo = product[31:0]; divide gives lo = quotient, hi = remainder.
- **Overflow**: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (truncated negation; no trap).
- **Ignored inputs**
  - `start` while busy: ignored.
  - `hi_wr`/`lo_wr` while busy: ignored.
  - In IDLE, `start` with `hi_wr`/`lo_wr` in the same cycle: `start` wins and the write is dropped.
  - `hi_wr` and `lo_wr` together: both apply.
- **Reset** (also mid-operation): state = IDLE, counter = 0, hi = lo = 0, `busy` = `done` = `div_by_zero` = 0. No pending result survives.

## Timing
- `start` accepted at edge E0 (normal operation):
  - `busy` = 1 from E0 to E33 (33 cycles: 32 RUN + 1 DONE).
  - HI/LO updated at E32.
  - `done` = 1 between E32 and E33.
  - Next `start` can be accepted at E33.
- Divide by zero:
  - HI/LO updated at E0.
  - `busy` = `done` = 1 for the single cycle E0–E1.
- MTHI/MTLO: HI/LO updated at the same edge; visible in the next cycle.
- `hi`/`lo` are registered outputs, stable from posedge. The register file writes on negedge, so MFHI/MFLO through the writeback mux is captured in the same cycle.
- The controller stalls issue while `busy` = 1. This unit has no internal interlock beyond ignoring `start`.

## Structure
- Shared package `muldiv_pkg`:
  - `op` encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - State enum.
  - Constant ITERATIONS = 32.
- One sub-module: `muldiv_signfix` (combinational). Takes a magnitude result and sign bits; produces the signed HI/LO pair. It is also used for operand absolute value.
- FSM, counter and datapath stay in `muldiv_unit`.

## Test plan
- MULT, rs = 0xFFFFFFFD (-3), rt = 5 → at E32 hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; `done` pulses once; `busy` is high for 33 cycles.
- MULTU, rs = rt = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. A second `start` at E5 is ignored (result unchanged, still done at E32).
- DIV, rs = 0xFFFFFFF9 (-7), rt = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU, rs = 100, rt = 7 → lo = 14, hi = 2.
- DIV, rs = 0x80000000, rt = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIV, rs = 5, rt = 0 → `div_by_zero` = 1, lo = 0xFFFFFFFF, hi = 5, `done` in the cycle after E0.
- MTHI 0x1234 then MTLO 0xABCD in IDLE → hi = 0x1234, lo = 0xABCD. The same strobes during RUN are ignored.
- `reset` at E10 of a MULT → next cycle `busy` = 0, hi = lo = 0, and no `done` pulse follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states, iteration count and small decode helpers.
package muldiv_pkg;

    // Operation encodings carried on the op input
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // One result bit is produced per RUN cycle
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True for DIV and DIVU
    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for the two's-complement variants MULT and DIV
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign correction for a HI/LO pair.
// Wide mode treats {hi, lo} as one 64-bit product and negates it as a whole
// when i_neg_lo is set. Narrow mode negates each half on its own, which
// serves both the quotient/remainder fix and operand absolute value.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic             i_wide,
    input  logic             i_neg_lo,
    input  logic             i_neg_hi,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] w_pair_neg;

    assign w_pair_neg = -{i_hi, i_lo};

    // Select pass-through or negated halves
    always_comb begin
        // NOTE: outputs get a default before any branch so no path leaves them unassigned (no latch).
        o_hi = i_hi;
        o_lo = i_lo;
        if (i_wide) begin
            if (i_neg_lo) begin
                o_hi = w_pair_neg[2*WIDTH-1:WIDTH];
                o_lo = w_pair_neg[WIDTH-1:0];
            end
        end else begin
            if (i_neg_lo) begin
                o_lo = -i_lo;
            end
            if (i_neg_hi) begin
                o_hi = -i_hi;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO special registers.
// Operands are reduced to magnitudes on acceptance, 32 shift-add or
// restoring-divide iterations run one per cycle, and the sign fix is applied
// on the last iteration as HI/LO are written. MTHI/MTLO write directly in IDLE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // Controller state
    state_t             r_state;
    logic [CNT_W-1:0]   r_count;

    // Datapath state: r_acc is {partial product high / remainder, multiplier / quotient}
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_operand;
    logic               r_is_div;
    logic               r_sign_rs;
    logic               r_sign_rt;

    // Architectural results
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    // Decode of the incoming request
    logic               w_accept;
    logic               w_is_div;
    logic               w_signed;
    logic               w_dbz;
    logic               w_last;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;

    // One iteration of each algorithm
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_is_div = op_is_div(op);
    assign w_signed = op_is_signed(op);
    assign w_dbz    = w_is_div && (rt_val == '0);
    assign w_last   = (r_count == CNT_W'(ITERATIONS - 1));

    // Absolute value of both operands for the signed variants
    muldiv_signfix #(.WIDTH(WIDTH)) u_operand_abs (
        .i_hi     (rt_val),
        .i_lo     (rs_val),
        .i_wide   (1'b0),
        .i_neg_lo (w_signed & rs_val[WIDTH-1]),
        .i_neg_hi (w_signed & rt_val[WIDTH-1]),
        .o_hi     (w_rt_mag),
        .o_lo     (w_rs_mag)
    );

    // Multiply: add the multiplicand into the upper half when the multiplier
    // LSB is set, then shift the whole 65-bit value right by one.
    assign w_add = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                 + (r_acc[0] ? {1'b0, r_operand} : '0);

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The remainder is always below the divisor, so the trial is below twice
    // the divisor and bit WIDTH of the difference is a clean borrow flag.
    assign w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, r_operand};
    assign w_fits  = ~w_diff[WIDTH];

    // Next accumulator value for the operation in flight
    always_comb begin
        w_acc_next = r_acc;
        if (r_is_div) begin
            w_acc_next = {(w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_fits};
        end else begin
            w_acc_next = {w_add, r_acc[WIDTH-1:1]};
        end
    end

    // Sign fix of the final magnitude result: product negates as a whole,
    // quotient follows sign(rs)^sign(rt), remainder follows sign(rs).
    muldiv_signfix #(.WIDTH(WIDTH)) u_result_fix (
        .i_hi     (w_acc_next[2*WIDTH-1:WIDTH]),
        .i_lo     (w_acc_next[WIDTH-1:0]),
        .i_wide   (~r_is_div),
        .i_neg_lo (r_sign_rs ^ r_sign_rt),
        .i_neg_hi (r_sign_rs),
        .o_hi     (w_fix_hi),
        .o_lo     (w_fix_lo)
    );

    // FSM and iteration counter
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        if (w_dbz) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture on accept, one iteration per RUN cycle
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; they are fully loaded on every accepted start
        // and nothing observes them outside RUN.
        if (w_accept) begin
            r_acc     <= {{WIDTH{1'b0}}, w_rs_mag};
            r_operand <= w_rt_mag;
            r_is_div  <= w_is_div;
            r_sign_rs <= w_signed & rs_val[WIDTH-1];
            r_sign_rt <= w_signed & rt_val[WIDTH-1];
        end else if (r_state == ST_RUN) begin
            r_acc     <= w_acc_next;
        end
    end

    // HI/LO and the sticky divide-by-zero flag; start has priority over MTHI/MTLO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= w_dbz;
            if (w_dbz) begin
                r_hi <= rs_val;
                r_lo <= '1;
            end
        end else if ((r_state == ST_RUN) && w_last) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if (r_state == ST_IDLE) begin
            if (hi_wr) begin
                r_hi <= wr_data;
            end
            if (lo_wr) begin
                r_lo <= wr_data;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed products, quotients and
// remainders, busy/done timing, divide by zero, MTHI/MTLO and reset abort.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch it on falling edges until busy drops.
    // Iteration i samples the cycle after edge E(i-1); a stimulus driven at
    // i = 5 is seen by edge E5.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic inj_start, input logic inj_wr,
                          output int n_busy, output int n_done, output int done_idx,
                          output logic [31:0] hi_d, output logic [31:0] lo_d);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        n_busy = 0;
        n_done = 0;
        done_idx = -1;
        hi_d = 'x;
        lo_d = 'x;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            start = 1'b0;
            hi_wr = 1'b0;
            lo_wr = 1'b0;
            if (i == 5) begin
                if (inj_start) begin
                    start  = 1'b1;
                    op     = OP_DIVU;
                    rs_val = 32'd100;
                    rt_val = 32'd7;
                end
                if (inj_wr) begin
                    hi_wr   = 1'b1;
                    lo_wr   = 1'b1;
                    wr_data = 32'h5555_5555;
                end
            end
            if (!busy) break;
            n_busy++;
            if (done) begin
                n_done++;
                done_idx = i;
                hi_d = hi;
                lo_d = lo;
            end
        end
    endtask

    // Full operation with result and timing checks
    task automatic op_test(input string name, input logic [1:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic inj_start, input logic inj_wr);
        int nb, nd, di;
        logic [31:0] hd, ld;
        run_op(o, a, b, inj_start, inj_wr, nb, nd, di, hd, ld);
        check({name, " busy_cycles"}, 64'(nb), 64'd33);
        check({name, " done_pulses"}, 64'(nd), 64'd1);
        check({name, " done_cycle"}, 64'(di), 64'd33);
        check({name, " hi_at_done"}, 64'(hd), 64'(exp_hi));
        check({name, " lo_at_done"}, 64'(ld), 64'(exp_lo));
        check({name, " hi_hold"}, 64'(hi), 64'(exp_hi));
        check({name, " lo_hold"}, 64'(lo), 64'(exp_lo));
        check({name, " dbz"}, 64'(div_by_zero), 64'd0);
    endtask

    initial begin
        int nb, nd, di, seen_done, seen_busy;
        logic [31:0] hd, ld;

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);

        // Multiply cases
        op_test("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 1'b0);
        op_test("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
        op_test("mult_extreme", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Divide cases
        op_test("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
        op_test("div_7bynegy2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
        op_test("divu_max_by2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        op_test("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

        // Divide by zero: one-cycle busy/done, sticky flag
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0, 1'b0, nb, nd, di, hd, ld);
        check("dbz busy_cycles", 64'(nb), 64'd1);
        check("dbz done_cycle", 64'(di), 64'd1);
        check("dbz hi", 64'(hd), 64'd5);
        check("dbz lo", 64'(ld), 64'hFFFF_FFFF);
        check("dbz flag", 64'(div_by_zero), 64'd1);
        repeat (3) @(negedge clk);
        check("dbz sticky", 64'(div_by_zero), 64'd1);

        // Next start clears the flag
        op_test("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

        // MTHI then MTLO in IDLE
        hi_wr = 1'b1;
        wr_data = 32'h0000_1234;
        @(negedge clk);
        hi_wr = 1'b0;
        check("mthi next_cycle", 64'(hi), 64'h1234);
        lo_wr = 1'b1;
        wr_data = 32'h0000_ABCD;
        @(negedge clk);
        lo_wr = 1'b0;
        check("mtlo hi", 64'(hi), 64'h1234);
        check("mtlo lo", 64'(lo), 64'hABCD);

        // start together with MTHI/MTLO: the write is dropped
        start = 1'b1;
        op = OP_MULTU;
        rs_val = 32'd3;
        rt_val = 32'd4;
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        check("start_wins busy", 64'(busy), 64'd1);
        check("start_wins hi", 64'(hi), 64'h1234);
        check("start_wins lo", 64'(lo), 64'hABCD);
        seen_busy = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            @(negedge clk);
            seen_busy++;
        end
        check("start_wins idle", 64'(busy), 64'd0);
        check("start_wins res_hi", 64'(hi), 64'd0);
        check("start_wins res_lo", 64'(lo), 64'd12);

        // MTHI/MTLO strobes during RUN are ignored (also a stray start)
        op_test("mult_wr_ignored", OP_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b1, 1'b1);

        // Reset at E10 of a MULT aborts with no done pulse
        @(negedge clk);
        start = 1'b1;
        op = OP_MULT;
        rs_val = 32'hFFFF_FFFD;
        rt_val = 32'd5;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (busy) seen_busy++;
        end
        check("abort no_done", 64'(seen_done), 64'd0);
        check("abort no_busy", 64'(seen_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
